count_change_fifo: RTL and testbench

//   Downstream consumer of the 4-bit up-counter. Samples the counter value every clk,

---
 rtl/count_change_fifo_if.sv | 24 ++
 rtl/count_change_fifo.sv | 92 +++++++++
 tb/tb_count_change_fifo.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/count_change_fifo_if.sv
// Output stream of count_change_fifo: head entry with a valid/ready handshake.
// master drives data/wrap/valid and samples ready; slave is the consumer.
interface count_change_fifo_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] out_data;
    logic             out_wrap;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_wrap,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_wrap,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/count_change_fifo.sv
// Samples a counter every clk and pushes each changed value (tagged with a
// MAX->0 wrap bit) into a FWFT FIFO.
// Ports: clk, rst (async active-low), count_in; out (stream interface);
// level (entries stored), overflow (sticky, a change was dropped while full).
module count_change_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         count_in,
    count_change_fifo_if.master      out,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] MAX = '1;

    typedef logic [WIDTH:0] entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW:0]     wr_ptr_q, wr_ptr_d;
    logic [PW:0]     rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic            base_ok_q, base_ok_d;
    logic            overflow_q, overflow_d;

    logic [PW:0]     lvl;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            wrap;
    entry_t          head;

    always_comb begin
        lvl   = wr_ptr_q - rd_ptr_q;
        empty = (lvl == '0);
        full  = (lvl == (PW+1)'(DEPTH));
        head  = mem_q[rd_ptr_q[PW-1:0]];

        out.out_valid = !empty;
        out.out_data  = empty ? '0 : head[WIDTH-1:0];
        out.out_wrap  = !empty && head[WIDTH];
        level         = lvl;
        overflow      = overflow_q;

        push = base_ok_q && (count_in != prev_q);
        wrap = (prev_q == MAX) && (count_in == '0);
        pop  = !empty && out.out_ready;

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        prev_d     = count_in;
        base_ok_d  = 1'b1;

        // When full, a same-cycle pop frees the slot the push lands in.
        if (push && (!full || pop)) begin
            mem_d[wr_ptr_q[PW-1:0]] = {wrap, count_in};
            wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        end else if (push) begin
            overflow_d = 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            prev_q     <= '0;
            base_ok_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            prev_q     <= prev_d;
            base_ok_q  <= base_ok_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_count_change_fifo.sv
// Bench for count_change_fifo: queue-based reference model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_count_change_fifo;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] count_in;
    logic [2:0]       level;
    logic             overflow;

    count_change_fifo_if #(.WIDTH(WIDTH)) bus ();

    count_change_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .count_in (count_in),
        .out      (bus),
        .level    (level),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {wrap,data} entries.
    logic [WIDTH:0]   q[$];
    logic [WIDTH-1:0] m_prev;
    logic             m_base;
    logic             m_ovf;
    logic             m_chg;
    logic             m_pop;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_prev = '0;
            m_base = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_pop = (q.size() > 0) && bus.out_ready;
            m_chg = m_base && (count_in != m_prev);
            if (m_pop) void'(q.pop_front());
            if (m_chg) begin
                if (q.size() < DEPTH)
                    q.push_back({(m_prev == 4'd15) && (count_in == 4'd0), count_in});
                else
                    m_ovf = 1'b1;
            end
            m_prev = count_in;
            m_base = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("m_valid", int'(bus.out_valid), int'(q.size() > 0));
            chk("m_data", int'(bus.out_data), q.size() > 0 ? int'(q[0][WIDTH-1:0]) : 0);
            chk("m_wrap", int'(bus.out_wrap), q.size() > 0 ? int'(q[0][WIDTH]) : 0);
            chk("m_level", int'(level), q.size());
            chk("m_ovf", int'(overflow), int'(m_ovf));
        end
    end

    task automatic step(input int c, input bit rdy);
        count_in      = WIDTH'(c);
        bus.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string n, input int v, input int d, input int w, input int l);
        chk({n, "_valid"}, int'(bus.out_valid), v);
        chk({n, "_data"}, int'(bus.out_data), d);
        chk({n, "_wrap"}, int'(bus.out_wrap), w);
        chk({n, "_level"}, int'(level), l);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        head("rst", 0, 0, 0, 0);
        chk("rst_ovf", int'(overflow), 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        rst           = 1'b0;
        count_in      = '0;
        bus.out_ready = 1'b0;
        #2;
        head("por", 0, 0, 0, 0);
        chk("por_ovf", int'(overflow), 0);
        @(negedge clk);
        rst = 1'b1;

        // Baseline 0, then 1,2,3 held
        step(0, 0);
        head("base0", 0, 0, 0, 0);
        step(1, 0);
        head("fill1", 1, 1, 0, 1);
        step(2, 0);
        head("fill2", 1, 1, 0, 2);
        step(3, 0);
        head("fill3", 1, 1, 0, 3);

        // Async reset with 3 entries stored, then baseline only
        do_reset();
        step(9, 0);
        head("rebase", 0, 0, 0, 0);

        // 14,15,0 streaming with ready=1
        step(14, 1);
        head("s14", 1, 14, 0, 1);
        step(15, 1);
        head("s15", 1, 15, 0, 1);
        step(0, 1);
        head("s0wrap", 1, 0, 1, 1);
        step(0, 1);
        head("sdone", 0, 0, 0, 0);

        // Constant after baseline 7
        do_reset();
        step(7, 0);
        for (int i = 0; i < 10; i++) begin
            step(7, 1);
            head("const", 0, 0, 0, 0);
        end

        // Full with simultaneous push+pop
        step(1, 0);
        step(2, 0);
        step(3, 0);
        step(4, 0);
        head("full", 1, 1, 0, 4);
        step(5, 1);
        head("pp", 1, 2, 0, 4);
        chk("pp_ovf", int'(overflow), 0);
        step(5, 1);
        head("pp_d3", 1, 3, 0, 3);
        step(5, 1);
        head("pp_d4", 1, 4, 0, 2);
        step(5, 1);
        head("pp_d5", 1, 5, 0, 1);
        step(5, 1);
        head("pp_end", 0, 0, 0, 0);

        // Overflow: 5 changes while stalled
        step(6, 0);
        step(7, 0);
        step(8, 0);
        step(9, 0);
        step(10, 0);
        head("ovf", 1, 6, 0, 4);
        chk("ovf_flag", int'(overflow), 1);
        step(10, 1);
        head("ovf_d7", 1, 7, 0, 3);
        step(10, 1);
        head("ovf_d8", 1, 8, 0, 2);
        step(10, 1);
        head("ovf_d9", 1, 9, 0, 1);
        step(10, 1);
        head("ovf_end", 0, 0, 0, 0);
        chk("ovf_sticky", int'(overflow), 1);

        // Jump to 0 from non-MAX carries no wrap tag
        step(0, 0);
        head("jump0", 1, 0, 0, 1);

        // Counting run with stalls, checked by the model
        do_reset();
        step(3, 0);
        for (int i = 0; i < 120; i++) begin
            step((i / ((i % 5) + 1)) % 16, (i % 3) != 0);
        end
        for (int i = 0; i < 8; i++) step(15, 1);
        head("tail", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
